// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, sigma helpers and the message-schedule state type.
package sha256_pkg;

   typedef enum logic [0:0] {StIdle, StRun} sched_state_e;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] H_INIT [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup, K[idx].
module sha256_k_rom
   import sha256_pkg::*;
(
   input  logic [5:0]  idx_i,
   output logic [31:0] k_o
);

   assign k_o = K[idx_i];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..63] with round index.
// Define SHA256_K_ROM_EN to also register K[round] on k_t_o; otherwise k_t_o is tied to 0.
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic [511:0] blk_i,
   output logic         w_valid_o,
   input  logic         w_ready_i,
   output logic [31:0]  w_t_o,
   output logic [31:0]  k_t_o,
   output logic [5:0]   round_o,
   output logic         w_last_o
);

   sched_state_e state_q, state_d;
   logic [31:0]  win_q [16];
   logic [31:0]  win_d [16];
   logic [5:0]   round_q, round_d;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      round_d = round_q;
      unique case (state_q)
         StIdle: begin
            if (blk_valid_i) begin
               for (int i = 0; i < 16; i++) begin
                  win_d[i] = blk_i[511 - 32*i -: 32];
               end
               round_d = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (w_ready_i) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i+1];
               end
               // Expansions from the final 16 rounds are computed but never reach win_q[0].
               win_d[15] = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
               round_d   = round_q + 6'd1;
               if (round_q == 6'd63) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         round_q <= '0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         win_q   <= win_d;
      end
   end

`ifdef SHA256_K_ROM_EN
   logic [31:0] k_d, k_q;

   sha256_k_rom u_k_rom (
      .idx_i (round_d),
      .k_o   (k_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q <= '0;
      end else begin
         k_q <= k_d;
      end
   end

   assign k_t_o = k_q;
`else
   assign k_t_o = '0;
`endif

   // Gated by reset so the block is never offered while reset is held.
   assign blk_ready_o = rst_ni && (state_q == StIdle);
   assign w_valid_o   = (state_q == StRun);
   assign w_t_o       = win_q[0];
   assign round_o     = round_q;
   assign w_last_o    = w_valid_o && (round_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: directed blocks, backpressure, back-to-back, reset.
module tb_sha256_msg_schedule;

   logic         clk;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_t;
   logic [31:0]  k_t;
   logic [5:0]   round;
   logic         w_last;

   sha256_msg_schedule dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .blk_valid_i (blk_valid),
      .blk_ready_o (blk_ready),
      .blk_i       (blk),
      .w_valid_o   (w_valid),
      .w_ready_i   (w_ready),
      .w_t_o       (w_t),
      .k_t_o       (k_t),
      .round_o     (round),
      .w_last_o    (w_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic [5:0]  r;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] exp_w  [64];
   logic [31:0] got_w  [64];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          first_hs = 0;
   int          last_hs  = 0;
   int          done_cnt = 0;
   int          accept_edge = 0;

   localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_HDR = {32'h02000000, {15{32'h0}}};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic void build_exp(input logic [511:0] b);
      for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                  + exp_w[t-7]
                  + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                  + exp_w[t-16];
      end
   endfunction

   function automatic void push_exp(input logic [511:0] b);
      exp_t e;
      build_exp(b);
      for (int t = 0; t < 64; t++) begin
         e.w    = exp_w[t];
         e.r    = 6'(t);
         e.last = (t == 63);
         sb.push_back(e);
      end
   endfunction

   // Monitor: a word is consumed at the next rising edge when valid && ready at the falling edge.
   always @(negedge clk) begin
      if (rst_n && w_valid) chk("blk_ready_in_run", {31'b0, blk_ready}, 32'd0);
      if (rst_n && w_valid && w_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", {26'b0, round}, 32'hffffffff);
         end else begin
            mon_e = sb.pop_front();
            chk("w_t", w_t, mon_e.w);
            chk("round", {26'b0, round}, {26'b0, mon_e.r});
            chk("w_last", {31'b0, w_last}, {31'b0, mon_e.last});
`ifdef SHA256_K_ROM_EN
            if (mon_e.r == 6'd0) chk("k_round0", k_t, 32'h428a2f98);
            else if (mon_e.r == 6'd63) chk("k_round63", k_t, 32'hc67178f2);
`else
            chk("k_zero", k_t, 32'h0);
`endif
            got_w[round] = w_t;
            if (round == 6'd0) first_hs = cyc + 1;
            if (w_last) begin
               last_hs = cyc + 1;
               done_cnt++;
            end
         end
      end
   end

   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (blk_ready && blk_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      accept_edge = cyc + 1;
   endtask

   task automatic issue(input logic [511:0] b);
      push_exp(b);
      blk       = b;
      blk_valid = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      chk("latency_valid", {31'b0, w_valid}, 32'd1);
      chk("latency_round", {26'b0, round}, 32'd0);
   endtask

   task automatic wait_done();
      int  start = done_cnt;
      bit  ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_round(input logic [5:0] r);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (w_valid && round == r) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("round_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_blk_ready"}, {31'b0, blk_ready}, 32'd0);
      chk({tag, "_w_valid"}, {31'b0, w_valid}, 32'd0);
      chk({tag, "_w_t"}, w_t, 32'd0);
      chk({tag, "_k_t"}, k_t, 32'd0);
      chk({tag, "_round"}, {26'b0, round}, 32'd0);
      chk({tag, "_w_last"}, {31'b0, w_last}, 32'd0);
   endtask

   initial begin
      logic [31:0] hw, hk;
      logic [5:0]  hr;
      rst_n     = 1'b1;
      blk_valid = 1'b0;
      blk       = '0;
      w_ready   = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ready_after_release", {31'b0, blk_ready}, 32'd1);

      // Free-running "abc" block.
      issue(BLK_ABC);
      wait_done();
      chk("abc_w0", got_w[0], 32'h61626380);
      chk("abc_w15", got_w[15], 32'h00000018);
      chk("abc_w16", got_w[16], 32'h61626380);
      chk("abc_w17", got_w[17], 32'h000f0000);
      chk("abc_w63", got_w[63], 32'h12b1edeb);
      chk("abc_span", 32'(last_hs - first_hs), 32'd63);

      // Backpressure: hold w_ready low for 5 cycles at round 20.
      issue(BLK_ABC);
      wait_round(6'd20);
      w_ready = 1'b0;
      hw = w_t;
      hr = round;
      hk = k_t;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_hold_w", w_t, hw);
         chk("bp_hold_round", {26'b0, round}, {26'b0, hr});
         chk("bp_hold_k", k_t, hk);
         chk("bp_hold_valid", {31'b0, w_valid}, 32'd1);
      end
      w_ready = 1'b1;
      wait_done();
      chk("bp_w63", got_w[63], 32'h12b1edeb);

      // Back-to-back: blk_valid held high across two blocks.
      push_exp(BLK_ABC);
      blk       = BLK_ABC;
      blk_valid = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
      blk = BLK_HDR;
      push_exp(BLK_HDR);
      wait_accept();
      @(posedge clk);
      #1;
      blk_valid = 1'b0;
      chk("b2b_gap", 32'(accept_edge), 32'(last_hs + 1));
      wait_done();
      chk("b2b_hdr_w0", got_w[0], 32'h02000000);
      chk("b2b_hdr_w16", got_w[16], 32'h02000000);

      // Reset mid-block at round 30, then restart.
      issue(BLK_ABC);
      wait_round(6'd30);
      rst_n = 1'b0;
      sb.delete();
      #1 check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("midrst_ready", {31'b0, blk_ready}, 32'd1);
      issue(BLK_HDR);
      wait_done();
      chk("hdr_w0", got_w[0], 32'h02000000);
      chk("hdr_w16", got_w[16], 32'h02000000);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
